vedic_mult8_pipe: RTL and testbench
===================================

# vedic_mult8_pipe

Pipelined 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier stage with valid/ready handshakes on both sides. It splits operands into 4-bit halves, forms four 4x4 partial products, then reduces them with full-adder cells and a 16-bit Brent-Kung final adder into a registered 16-bit product. It sits between the operand source and the product consumer, and is the sequential wrapper around the datapath's full-adder and Brent-Kung adder cells.

## Interface
Parameters:
- none; widths are fixed at 8x8 -> 16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present on a/b.
- in_ready  out  1  block accepts operands this cycle.
- a  in  8  unsigned multiplicand.
- b  in  8  unsigned multiplier.
- out_valid  out  1  product p valid.
- out_ready  in  1  consumer accepts p this cycle.
- p  out  16  unsigned product a*b.

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Stage S1 captures a, b and computes the partial products ll=a[3:0]*b[3:0], lh=a[3:0]*b[7:4], hl=a[7:4]*b[3:0], hh=a[7:4]*b[7:4] (each 8 bits). Registers ll, lh, hl, hh and s1_valid.
- Stage S2 computes mid = lh + hl (9 bits, full-adder ripple) and p_next = {hh,ll} + (mid << 4) (16-bit Brent-Kung). Registers p and out_valid.
- Arithmetic is exact: the maximum is 255*255 = 0xFE01, so nothing overflows 16 bits and no carry-out is kept.
- Flow control: each stage advances when its output register is empty or is being drained in the same cycle. S2 loads when !out_valid | out_ready. S1 loads when !s1_valid | S2 loads.
- in_ready = !s1_valid | !out_valid | out_ready. It is combinational from the register state and out_ready only; it never depends on in_valid.
- Stalled stages hold their data bit-stable. While out_valid=1 & out_ready=0, p must not change.
- No bubbles are inserted. With in_valid and out_ready held at 1, the block accepts one operand pair and delivers one product per cycle.
- Ordering is strictly FIFO; no result is dropped or duplicated.

## Timing
- Reset (async assert, sync-safe release): s1_valid=0, out_valid=0, p=16'h0000, and the ll/lh/hl/hh registers are 0. in_ready reads 1 during and after reset.
- Latency is 2 cycles from an accepted input edge to out_valid=1, when there is no backpressure.
- Throughput is 1 per cycle when out_ready=1.
- Full condition: s1_valid=1, out_valid=1 and out_ready=0 give in_ready=0.
- Simultaneous drain and fill: if out_valid & out_ready and S1 holds data, S2 reloads in the same edge and out_valid stays 1.
- Reset mid-operation discards all in-flight products. out_valid drops asynchronously on rst_n=0.
- a and b are don't-care when in_valid=0. The internal registers load only on an accepted transfer.

## Configuration
- VEDIC_MID_REG_EN:
  - Defined: an extra stage SM is inserted between S1 and S2. SM registers mid (9 bits), ll and hh, with its own valid bit and the same advance rule. Latency becomes 3 cycles; throughput is still 1 per cycle. in_ready = !s1_valid | S1 advances, computed through the chain. SM registers reset to 0.
  - Undefined: the 2-stage datapath described above, with latency 2.
- The functional result is identical in both builds.

## Test plan
- Reset: hold rst_n=0 with random inputs -> out_valid=0, p=0x0000, in_ready=1. Release -> no spurious out_valid.
- Corners: (a=0xFF,b=0xFF) -> p=0xFE01. (0x00,0xA5) -> 0x0000. (0x01,0xB7) -> 0x00B7. (0x80,0x02) -> 0x0100. (0x0F,0xF0) -> 0x0E10. Each must appear 2 cycles after acceptance (3 with VEDIC_MID_REG_EN).
- Streaming: feed 256 consecutive pairs (a=i, b=255-i) with out_ready=1 -> 256 in-order products on consecutive cycles, with no gaps after the initial latency.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 (3) pairs are accepted, in_ready=0 after that, and p is held stable. Then out_ready=1 -> all products drain in order, none lost or duplicated.
- Random: 10k random pairs with random in_valid/out_ready duty -> a scoreboard matches a*b for every transfer.
- Mid-flight reset: assert rst_n=0 while 2 products are in flight -> out_valid=0 immediately. After release, the first output corresponds only to a post-reset input.

Source files
------------

// File: rtl/vedic_mult8_pipe.sv
// Pipelined 8x8 Vedic multiplier: 4x4 partial products, FA mid-sum, BK final add.
// Define VEDIC_MID_REG_EN to register the mid-sum in an extra stage (latency 3).

module vedic_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module vedic_bk16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] s
);
    logic [15:0] g;
    logic [15:0] t;
    logic [15:0] h;

    always_comb begin
        g = x & y;
        t = x ^ y;
        h = t;
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
                g[i] = g[i] | (t[i] & g[i - d]);
                t[i] = t[i] & t[i - d];
            end
        end
        // down-sweep fills in the carries the up-sweep tree skipped
        for (int d = 4; d > 0; d = d / 2) begin
            for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
                g[i] = g[i] | (t[i] & g[i - d]);
                t[i] = t[i] & t[i - d];
            end
        end
        s = h ^ {g[14:0], 1'b0};
    end
endmodule

module vedic_mult8_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p
);
    logic        s1_valid;
    logic [7:0]  ll_q;
    logic [7:0]  lh_q;
    logic [7:0]  hl_q;
    logic [7:0]  hh_q;
    logic        s1_load;
    logic        s2_load;
    logic        s2_src_valid;
    logic [8:0]  carry;
    logic [8:0]  mid;
    logic [15:0] add_x;
    logic [15:0] add_y;
    logic [15:0] p_next;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_mid
        vedic_fa u_fa (
            .x  (lh_q[i]),
            .y  (hl_q[i]),
            .ci (carry[i]),
            .s  (mid[i]),
            .co (carry[i+1])
        );
    end

    assign mid[8]  = carry[8];
    assign s2_load = !out_valid | out_ready;

`ifdef VEDIC_MID_REG_EN
    logic       sm_valid;
    logic       sm_load;
    logic [8:0] mid_q;
    logic [7:0] sm_ll_q;
    logic [7:0] sm_hh_q;

    assign sm_load      = !sm_valid | s2_load;
    assign s1_load      = !s1_valid | sm_load;
    assign s2_src_valid = sm_valid;
    assign add_x        = {sm_hh_q, sm_ll_q};
    assign add_y        = {3'b000, mid_q, 4'b0000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_valid <= 1'b0;
            mid_q    <= '0;
            sm_ll_q  <= '0;
            sm_hh_q  <= '0;
        end else if (sm_load) begin
            sm_valid <= s1_valid;
            if (s1_valid) begin
                mid_q   <= mid;
                sm_ll_q <= ll_q;
                sm_hh_q <= hh_q;
            end
        end
    end
`else
    assign s1_load      = !s1_valid | s2_load;
    assign s2_src_valid = s1_valid;
    assign add_x        = {hh_q, ll_q};
    assign add_y        = {3'b000, mid, 4'b0000};
`endif

    assign in_ready = s1_load;

    vedic_bk16 u_bk (
        .x (add_x),
        .y (add_y),
        .s (p_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            ll_q     <= '0;
            lh_q     <= '0;
            hl_q     <= '0;
            hh_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                ll_q <= {4'h0, a[3:0]} * {4'h0, b[3:0]};
                lh_q <= {4'h0, a[3:0]} * {4'h0, b[7:4]};
                hl_q <= {4'h0, a[7:4]} * {4'h0, b[3:0]};
                hh_q <= {4'h0, a[7:4]} * {4'h0, b[7:4]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            p         <= '0;
        end else if (s2_load) begin
            out_valid <= s2_src_valid;
            if (s2_src_valid) begin
                p <= p_next;
            end
        end
    end
endmodule

// File: tb/tb_vedic_mult8_pipe.sv
// Directed and random bench for vedic_mult8_pipe.
// Drives and samples on the falling edge of clk.
`timescale 1ns/1ps

module tb_vedic_mult8_pipe;
`ifdef VEDIC_MID_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] p;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_p;

    vedic_mult8_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit hit, want finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            a = 8'($urandom);
            b = 8'($urandom);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || p !== 16'h0000 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold: ov=%b p=%h rdy=%b want 0 0000 1",
                         out_valid, p, in_ready);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release: ov=%b rdy=%b want 0 1",
                         out_valid, in_ready);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0]  va [5];
        logic [7:0]  vb [5];
        logic [15:0] vp [5];
        va[0] = 8'hFF; vb[0] = 8'hFF; vp[0] = 16'hFE01;
        va[1] = 8'h00; vb[1] = 8'hA5; vp[1] = 16'h0000;
        va[2] = 8'h01; vb[2] = 8'hB7; vp[2] = 16'h00B7;
        va[3] = 8'h80; vb[3] = 8'h02; vp[3] = 16'h0100;
        va[4] = 8'h0F; vb[4] = 8'hF0; vp[4] = 16'h0E10;
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            a = va[v];
            b = vb[v];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL corner_ready[%0d]: rdy=%b want 1", v, in_ready);
            end
            for (int c = 1; c <= LAT; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                n_checks++;
                if (c == LAT) begin
                    if (out_valid !== 1'b1 || p !== vp[v]) begin
                        n_fail++;
                        $display("FAIL corner[%0d]: ov=%b p=%h want 1 %h",
                                 v, out_valid, p, vp[v]);
                    end
                end else if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL corner_early[%0d]: ov=%b want 0", v, out_valid);
                end
            end
        end
    endtask

    task automatic test_streaming();
        int k;
        out_ready = 1'b1;
        for (int c = 0; c < 256 + LAT + 2; c++) begin
            @(negedge clk);
            if (c < 256) begin
                in_valid = 1'b1;
                a = 8'(c);
                b = 8'(255 - c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (c >= LAT && c < 256 + LAT) begin
                k = c - LAT;
                exp_p = 16'(k * (255 - k));
                if (out_valid !== 1'b1 || p !== exp_p) begin
                    n_fail++;
                    $display("FAIL stream[%0d]: ov=%b p=%h want 1 %h",
                             k, out_valid, p, exp_p);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_idle[c=%0d]: ov=%b want 0", c, out_valid);
            end
            if (c < 256) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ready[c=%0d]: rdy=%b want 1", c, in_ready);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          acc;
        int          got;
        bit          have_held;
        logic [15:0] held;
        acc = 0;
        got = 0;
        have_held = 1'b0;
        held = '0;
        sb.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 8'(17 * (acc + 1));
            b = 8'(3 + acc);
            #1;
            if (in_ready) begin
                sb.push_back({8'h00, a} * {8'h00, b});
                acc++;
            end
            if (out_valid) begin
                if (!have_held) begin
                    held = p;
                    have_held = 1'b1;
                end else begin
                    n_checks++;
                    if (p !== held) begin
                        n_fail++;
                        $display("FAIL bp_hold: p=%h want %h", p, held);
                    end
                end
            end
        end
        n_checks++;
        if (acc != LAT) begin
            n_fail++;
            $display("FAIL bp_accept_count: got=%0d want %0d", acc, LAT);
        end
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: rdy=%b ov=%b want 0 1", in_ready, out_valid);
        end
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                n_checks++;
                got++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_dup: p=%h want no output", p);
                end else begin
                    exp_p = sb.pop_front();
                    if (p !== exp_p) begin
                        n_fail++;
                        $display("FAIL bp_order: p=%h want %h", p, exp_p);
                    end
                end
            end
        end
        n_checks++;
        if (got != LAT || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain_count: got=%0d left=%0d want %0d 0",
                     got, sb.size(), LAT);
        end
    endtask

    task automatic test_random();
        int          acc;
        int          cyc;
        bit          stall;
        logic [15:0] lastp;
        acc = 0;
        cyc = 0;
        stall = 1'b0;
        lastp = '0;
        sb.delete();
        while (acc < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            #1;
            if (stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || p !== lastp) begin
                    n_fail++;
                    $display("FAIL rand_stall: ov=%b p=%h want 1 %h",
                             out_valid, p, lastp);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: p=%h want no output", p);
                end else begin
                    exp_p = sb.pop_front();
                    if (p !== exp_p) begin
                        n_fail++;
                        $display("FAIL rand_data: p=%h want %h", p, exp_p);
                    end
                end
            end
            stall = out_valid && !out_ready;
            lastp = p;
            if (in_valid && in_ready) begin
                sb.push_back({8'h00, a} * {8'h00, b});
                acc++;
            end
        end
        n_checks++;
        if (acc < 10000) begin
            n_fail++;
            $display("FAIL rand_budget: accepted=%0d want 10000", acc);
        end
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_drain_extra: p=%h want none", p);
                end else begin
                    exp_p = sb.pop_front();
                    if (p !== exp_p) begin
                        n_fail++;
                        $display("FAIL rand_drain: p=%h want %h", p, exp_p);
                    end
                end
            end
        end
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_empty: left=%0d ov=%b want 0 0",
                     sb.size(), out_valid);
        end
    endtask

    task automatic test_midflight_reset();
        int got;
        got = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h12;
        b = 8'h34;
        @(negedge clk);
        a = 8'h56;
        b = 8'h78;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || p !== 16'h0000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: ov=%b p=%h rdy=%b want 0 0000 1",
                     out_valid, p, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        a = 8'h33;
        b = 8'h03;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                n_checks++;
                got++;
                if (p !== 16'h0099 || c != LAT) begin
                    n_fail++;
                    $display("FAIL post_reset_out: p=%h c=%0d want 0099 %0d",
                             p, c, LAT);
                end
            end
        end
        n_checks++;
        if (got != 1) begin
            n_fail++;
            $display("FAIL post_reset_count: got=%0d want 1", got);
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_streaming();
        test_backpressure();
        test_random();
        test_midflight_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
